// File: rtl/tx_comp_frame_inserter_if.sv
// tx_comp_frame_inserter_if: frame-stream bundle around the compensation
// frame inserter. 'master' is the inserter itself (accepts user frames on s_*,
// sources the outgoing stream on m_*); 'slave' is the surrounding logic.
interface tx_comp_frame_inserter_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_vld;
    logic                  s_rdy;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_vld;
    logic                  m_rdy;
    logic                  m_is_comp;

    modport master (
        input  s_data, s_vld, m_rdy,
        output s_rdy, m_data, m_vld, m_is_comp
    );

    modport slave (
        output s_data, s_vld, m_rdy,
        input  s_rdy, m_data, m_vld, m_is_comp
    );
endinterface

// File: rtl/tx_comp_frame_inserter.sv
// tx_comp_frame_inserter: inserts one clock-compensation (idle) frame into the
// TX frame stream for every cycle 'compensate' is sampled high. User frames wait
// in a 2-entry skid buffer while compensation frames own the output slot; after
// MAX_CONSEC back-to-back compensation frames one waiting user frame is let through.
// Optional feature macro: COMP_STATS_EN (builds the comp_inserted transfer counter;
// otherwise comp_inserted is tied to zero).
module tx_comp_frame_inserter #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] COMP_PATTERN = 64'h1E00_0000_0000_0000,
    parameter int                    PEND_WIDTH   = 5,
    parameter int                    MAX_CONSEC   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     compensate,
    tx_comp_frame_inserter_if.master bus,
    output logic [PEND_WIDTH-1:0]    comp_pending,
    output logic                     comp_overflow,
    output logic [15:0]              comp_inserted
);
    typedef enum logic {COMP_OK, DATA_TURN} arb_state_t;

    localparam logic [3:0]            MAX_C    = 4'(MAX_CONSEC);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    arb_state_t            state;
    logic [3:0]            consec;
    logic [3:0]            consec_inc;
    logic [DATA_WIDTH-1:0] skid_q [2];
    logic [DATA_WIDTH-1:0] skid_n [2];
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_n;
    logic                  slot_open;
    logic                  skid_nonempty;
    logic                  pend_nz;
    logic                  push;
    logic                  load_comp;
    logic                  load_data;

    // Slot arbitration: decide what (if anything) enters the output register.
    always_comb begin
        slot_open     = ~bus.m_vld | bus.m_rdy;
        skid_nonempty = (cnt_q != 2'd0);
        pend_nz       = (comp_pending != '0);
        push          = bus.s_vld & bus.s_rdy;
        // A waiting user frame wins when it is owed a turn or nothing is pending.
        load_data     = slot_open & skid_nonempty & ((state == DATA_TURN) | ~pend_nz);
        load_comp     = slot_open & pend_nz & ~((state == DATA_TURN) & skid_nonempty);
        // Leaving DATA_TURN with an empty skid starts a fresh compensation run.
        if (state == DATA_TURN) begin
            consec_inc = 4'd1;
        end else if (consec == 4'hF) begin
            consec_inc = consec;
        end else begin
            consec_inc = consec + 4'd1;
        end
    end

    // Skid buffer next state: pop the head into the output, then append the new frame.
    // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
    // every output gets its default first, which is what keeps this block latch-free.
    always_comb begin
        skid_n = skid_q;
        cnt_n  = cnt_q;
        if (load_data) begin
            skid_n[0] = skid_q[1];
            cnt_n     = cnt_q - 2'd1;
        end
        if (push) begin
            skid_n[cnt_n[0]] = bus.s_data;
            cnt_n            = cnt_n + 2'd1;
        end
    end

    // Skid storage and registered ready (ready = room left after this cycle's moves).
    // NOTE: sequential blocks use non-blocking '<=' so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two skid entries are reset along with everything else; at this
            // depth it is cheap, and it keeps stale payload from ever reaching m_data.
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            cnt_q     <= 2'd0;
            bus.s_rdy <= 1'b0;
        end else begin
            skid_q    <= skid_n;
            cnt_q     <= cnt_n;
            bus.s_rdy <= (cnt_n != 2'd2);
        end
    end

    // Arbitration FSM with registered output frame, valid and comp flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= COMP_OK;
            consec        <= 4'd0;
            bus.m_data    <= '0;
            bus.m_vld     <= 1'b0;
            bus.m_is_comp <= 1'b0;
        end else if (slot_open) begin
            if (load_comp) begin
                bus.m_data    <= COMP_PATTERN;
                bus.m_vld     <= 1'b1;
                bus.m_is_comp <= 1'b1;
                consec        <= consec_inc;
                state         <= (consec_inc >= MAX_C && skid_nonempty) ? DATA_TURN : COMP_OK;
            end else if (load_data) begin
                bus.m_data    <= skid_q[0];
                bus.m_vld     <= 1'b1;
                bus.m_is_comp <= 1'b0;
                consec        <= 4'd0;
                state         <= COMP_OK;
            end else begin
                bus.m_vld     <= 1'b0;
                bus.m_is_comp <= 1'b0;
                consec        <= 4'd0;
                state         <= COMP_OK;
            end
        end
    end

    // Pending-request counter: saturating, with a sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_pending  <= '0;
            comp_overflow <= 1'b0;
        end else if (compensate && !load_comp) begin
            if (comp_pending == PEND_MAX) begin
                comp_overflow <= 1'b1;
            end else begin
                comp_pending <= comp_pending + 1'b1;
            end
        end else if (!compensate && load_comp) begin
            comp_pending <= comp_pending - 1'b1;
        end
    end

`ifdef COMP_STATS_EN
    // Count compensation frames accepted downstream; wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comp_inserted <= 16'd0;
        end else if (bus.m_vld && bus.m_rdy && bus.m_is_comp) begin
            comp_inserted <= comp_inserted + 16'd1;
        end
    end
`else
    assign comp_inserted = 16'd0;
`endif

endmodule
